// File: rtl/clock_pkg.sv
// Shared types and limits for the clock/mode controller.
package clock_pkg;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    SET_HR  = 2'd1,
    SET_MIN = 2'd2
  } state_t;

  localparam logic [5:0] SEC_MAX = 6'd59;
  localparam logic [5:0] MIN_MAX = 6'd59;
  localparam logic [4:0] HR_MAX  = 5'd23;

endpackage

// File: rtl/rise_detect.sv
// Rising-edge detector for a synchronous, debounced level.
// History clears on reset, so a level held high across release still yields one event.
module rise_detect (
  input  logic clk,
  input  logic reset,
  input  logic level,
  output logic pulse
);

  logic prev;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) prev <= 1'b0;
    else       prev <= level;
  end

  assign pulse = level & ~prev;

endmodule

// File: rtl/clock_mode_ctrl.sv
// Time-of-day counter with RUN / SET_HR / SET_MIN edit modes and a blink phase.
// Button edges act on the clock edge that samples them; all outputs come from registers.
module clock_mode_ctrl
  import clock_pkg::*;
#(
  parameter int BLINK_TICKS = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic       btn_mode,
  input  logic       btn_inc,
  output logic [4:0] hours,
  output logic [5:0] minutes,
  output logic [5:0] seconds,
  output logic [1:0] mode,
  output logic       blink,
  output logic       min_pulse
);

  localparam logic [3:0] BLINK_LAST = 4'(BLINK_TICKS - 1);

  state_t     state, next_state;
  logic       mode_ev, inc_ev;
  logic [3:0] blink_cnt;

  rise_detect u_mode_edge (.clk(clk), .reset(reset), .level(btn_mode), .pulse(mode_ev));
  rise_detect u_inc_edge  (.clk(clk), .reset(reset), .level(btn_inc),  .pulse(inc_ev));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= RUN;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    if (mode_ev) begin
      case (state)
        RUN:     next_state = SET_HR;
        SET_HR:  next_state = SET_MIN;
        default: next_state = RUN;
      endcase
    end
  end

  assign mode = state;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hours     <= '0;
      minutes   <= '0;
      seconds   <= '0;
      blink     <= 1'b0;
      blink_cnt <= '0;
      min_pulse <= 1'b0;
    end else begin
      min_pulse <= 1'b0;

      // Any state change restarts the blink phase, even if a tick lands in the same cycle.
      if (next_state != state) begin
        blink     <= 1'b0;
        blink_cnt <= '0;
      end else if (state != RUN && tick) begin
        if (blink_cnt == BLINK_LAST) begin
          blink     <= ~blink;
          blink_cnt <= '0;
        end else begin
          blink_cnt <= blink_cnt + 4'd1;
        end
      end

      case (state)
        RUN: begin
          if (tick) begin
            if (seconds == SEC_MAX) begin
              seconds   <= '0;
              min_pulse <= 1'b1;
              if (minutes == MIN_MAX) begin
                minutes <= '0;
                hours   <= (hours == HR_MAX) ? '0 : hours + 5'd1;
              end else begin
                minutes <= minutes + 6'd1;
              end
            end else begin
              seconds <= seconds + 6'd1;
            end
          end
        end
        SET_HR: begin
          if (inc_ev && !mode_ev)
            hours <= (hours == HR_MAX) ? '0 : hours + 5'd1;
        end
        SET_MIN: begin
          if (mode_ev)
            seconds <= '0;
          else if (inc_ev)
            minutes <= (minutes == MIN_MAX) ? '0 : minutes + 6'd1;
        end
        default: ;
      endcase
    end
  end

endmodule
